// File: rtl/nn_pkg.sv
// Shared constants for the NN Wishbone controller: register offsets,
// CTRL/STATUS bit positions and the launch FSM state encoding.
package nn_pkg;

  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RESULT = 8'h10;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_RM_LSB     = 1;
  localparam int CTRL_RM_MSB     = 3;
  localparam int CTRL_IRQ_EN_BIT = 4;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_TIMEOUT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } nn_state_e;

endpackage

// File: rtl/nn_launch_fsm.sv
// Launch sequencer for the NN core: IDLE -> LAUNCH (one-cycle in_valid) -> WAIT,
// returning to IDLE on the core's result valid or after TIMEOUT_CYC WAIT cycles.
module nn_launch_fsm
  import nn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 128
) (
  input  logic      clk,
  input  logic      rst_l,
  input  logic      start_i,
  input  logic      nn_out_valid_i,
  output logic      in_valid_o,
  output logic      launch_o,
  output logic      done_set_o,
  output logic      timeout_set_o,
  output nn_state_e state_o
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  nn_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A valid in the final WAIT cycle takes priority over the timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    launch_o      = 1'b0;
    done_set_o    = 1'b0;
    timeout_set_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_LAUNCH;
          launch_o = 1'b1;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (nn_out_valid_i) begin
          done_set_o = 1'b1;
          state_d    = ST_IDLE;
          cnt_d      = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout_set_o = 1'b1;
          state_d       = ST_IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_valid_o = (state_q == ST_LAUNCH);
  assign state_o    = state_q;

endmodule

// File: rtl/nn_wb_ctrl.sv
// Wishbone slave register window that launches the NN core and captures its result.
// Optional macro NN_WB_IRQ_EN enables the CTRL.irq_en bit and a registered irq_o.
module nn_wb_ctrl
  import nn_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYC = 128
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] opA_o,
  output logic [31:0] opB_o,
  output logic [2:0]  round_mode_o,
  output logic        in_valid_o,
  input  logic [31:0] nn_result_i,
  input  logic        nn_out_valid_i,
  output logic        irq_o
);

  logic [31:0] off;
  logic        req, wr, rd;
  logic        sel_opa, sel_opb, sel_ctrl, sel_status, sel_result;
  logic        busy, start, launch, done_set, timeout_set;
  nn_state_e   fsm_state;
  logic [31:0] rdata;

  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  rm_q, rm_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        irq_en;

  // Handshake: a request is cyc&stb while no ack is outstanding; it is acked by a
  // one-cycle ack_q exactly one cycle later, and the cycle after an ack never acks.
  assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr  = req & wbs_we_i;
  assign rd  = req & ~wbs_we_i;

  assign off        = wbs_adr_i - BASE_ADDR;
  assign sel_opa    = (off == {24'b0, OFF_OPA});
  assign sel_opb    = (off == {24'b0, OFF_OPB});
  assign sel_ctrl   = (off == {24'b0, OFF_CTRL});
  assign sel_status = (off == {24'b0, OFF_STATUS});
  assign sel_result = (off == {24'b0, OFF_RESULT});

  assign busy  = (fsm_state != ST_IDLE);
  assign start = wr & sel_ctrl & wbs_dat_i[CTRL_START_BIT];

  nn_launch_fsm #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fsm (
    .clk            (clk),
    .rst_l          (rst_l),
    .start_i        (start),
    .nn_out_valid_i (nn_out_valid_i),
    .in_valid_o     (in_valid_o),
    .launch_o       (launch),
    .done_set_o     (done_set),
    .timeout_set_o  (timeout_set),
    .state_o        (fsm_state)
  );

  always_comb begin
    rdata = '0;
    if (sel_opa) begin
      rdata = opa_q;
    end else if (sel_opb) begin
      rdata = opb_q;
    end else if (sel_ctrl) begin
      rdata[CTRL_RM_MSB:CTRL_RM_LSB] = rm_q;
      rdata[CTRL_IRQ_EN_BIT]         = irq_en;
    end else if (sel_status) begin
      rdata[STAT_BUSY_BIT]    = busy;
      rdata[STAT_DONE_BIT]    = done_q;
      rdata[STAT_TIMEOUT_BIT] = timeout_q;
    end else if (sel_result) begin
      rdata = result_q;
    end
  end

  // Operands and rounding mode are frozen while a run is in flight.
  always_comb begin
    ack_d     = req;
    rdat_d    = rd ? rdata : 32'h0;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rm_d      = rm_q;
    result_d  = result_q;
    done_d    = done_q;
    timeout_d = timeout_q;

    if (wr & sel_opa & ~busy) opa_d = wbs_dat_i;
    if (wr & sel_opb & ~busy) opb_d = wbs_dat_i;
    if (wr & sel_ctrl & ~busy) rm_d = wbs_dat_i[CTRL_RM_MSB:CTRL_RM_LSB];

    if (wr & sel_status & wbs_dat_i[STAT_DONE_BIT])    done_d    = 1'b0;
    if (wr & sel_status & wbs_dat_i[STAT_TIMEOUT_BIT]) timeout_d = 1'b0;
    if (launch) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end
    // Hardware sets come last so they win over a same-cycle W1C.
    if (done_set) begin
      done_d   = 1'b1;
      result_d = nn_result_i;
    end
    if (timeout_set) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rm_q      <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rm_q      <= rm_d;
      result_q  <= result_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef NN_WB_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  // irq tracks the post-edge flag values so it drops together with a W1C.
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr & sel_ctrl) irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
    irq_d = irq_en_d & (done_d | timeout_d);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq_o  = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = rdat_q;
  assign opA_o        = opa_q;
  assign opB_o        = opb_q;
  assign round_mode_o = rm_q;

endmodule

// File: tb/tb_nn_wb_ctrl.sv
// Self-checking bench for nn_wb_ctrl: an edge-indexed behavioural model of the
// register window and run timing, compared on every falling edge, plus directed literals.
module tb_nn_wb_ctrl;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          TMO    = 128;
  localparam logic [31:0] A_OPA  = BASE + 32'h00;
  localparam logic [31:0] A_OPB  = BASE + 32'h04;
  localparam logic [31:0] A_CTRL = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_RES  = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] dat_o, opa, opb;
  logic [2:0]  rm;
  logic        inv;
  logic [31:0] nn_res = '0;
  logic        nn_val = 1'b0;
  logic        irq;

  int checks = 0;
  int passed = 0;
  int pulse_cnt = 0;
  int p0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  nn_wb_ctrl #(.BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .wbs_cyc_i      (cyc),
    .wbs_stb_i      (stb),
    .wbs_we_i       (we),
    .wbs_adr_i      (adr),
    .wbs_dat_i      (dat),
    .wbs_ack_o      (ack),
    .wbs_dat_o      (dat_o),
    .opA_o          (opa),
    .opB_o          (opb),
    .round_mode_o   (rm),
    .in_valid_o     (inv),
    .nn_result_i    (nn_res),
    .nn_out_valid_i (nn_val),
    .irq_o          (irq)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_opa = '0, m_opb = '0, m_result = '0, m_rdata = '0;
  logic [2:0]  m_rm = '0;
  logic        m_irq_en = 1'b0, m_done = 1'b0, m_timeout = 1'b0, m_run = 1'b0;
  logic        m_ack = 1'b0, m_irq = 1'b0;
  int          m_n = 0, m_launch = -10;
  logic        t_req, t_wr, t_busy, t_inwait, t_dset, t_tset;
  logic [31:0] t_off;

  function automatic logic [31:0] model_read(input logic [31:0] off);
    logic [31:0] v;
    v = '0;
    case (off)
      32'h00:  v = m_opa;
      32'h04:  v = m_opb;
      32'h08:  v = {27'b0, m_irq_en, m_rm, 1'b0};
      32'h0C:  v = {29'b0, m_timeout, m_done, m_run};
      32'h10:  v = m_result;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Edge L launches a run: LAUNCH spans L..L+1, WAIT starts at L+1, and the
  // TMO-th WAIT cycle ends at edge L+1+TMO.
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_opa = '0; m_opb = '0; m_result = '0; m_rdata = '0; m_rm = '0;
      m_irq_en = 1'b0; m_done = 1'b0; m_timeout = 1'b0; m_run = 1'b0;
      m_ack = 1'b0; m_irq = 1'b0; m_n = 0; m_launch = -10;
    end else begin
      m_n++;
      t_busy   = m_run;
      t_req    = cyc && stb && !m_ack;
      t_wr     = t_req && we;
      t_off    = adr - BASE;
      t_inwait = m_run && (m_n >= m_launch + 2);
      t_dset   = t_inwait && nn_val;
      t_tset   = t_inwait && !nn_val && (m_n == m_launch + 1 + TMO);
      m_rdata  = (t_req && !we) ? model_read(t_off) : 32'h0;
      m_ack    = t_req;
      if (t_wr) begin
        if (t_off == 32'h00 && !t_busy) m_opa = dat;
        if (t_off == 32'h04 && !t_busy) m_opb = dat;
        if (t_off == 32'h08) begin
          if (!t_busy) m_rm = dat[3:1];
`ifdef NN_WB_IRQ_EN
          m_irq_en = dat[4];
`endif
          if (dat[0] && !t_busy) begin
            m_run = 1'b1; m_launch = m_n; m_done = 1'b0; m_timeout = 1'b0;
          end
        end
        if (t_off == 32'h0C) begin
          if (dat[1]) m_done = 1'b0;
          if (dat[2]) m_timeout = 1'b0;
        end
      end
      if (t_dset) begin m_result = nn_res; m_done = 1'b1; m_run = 1'b0; end
      if (t_tset) begin m_timeout = 1'b1; m_run = 1'b0; end
      m_irq = m_irq_en && (m_done || m_timeout);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("ack", {31'b0, ack}, {31'b0, m_ack});
    check("dat_o", dat_o, m_rdata);
    check("opA", opa, m_opa);
    check("opB", opb, m_opb);
    check("round_mode", {29'b0, rm}, {29'b0, m_rm});
    check("in_valid", {31'b0, inv}, {31'b0, (m_run && m_n == m_launch)});
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    if (inv) pulse_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic bus_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    @(posedge clk); #1;
    check("ack_latency", {31'b0, ack}, 32'd1);
    last_rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bus_req(1'b1, a, d);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus_req(1'b0, a, 32'h0);
    check(name, last_rd, exp);
  endtask

  task automatic nn_pulse(input logic [31:0] v);
    @(posedge clk); #1;
    nn_val = 1'b1; nn_res = v;
    @(posedge clk); #1;
    nn_val = 1'b0; nn_res = 32'h0;
  endtask

  task automatic wait_inval(input int max_cyc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk);
      if (inv) found = 1'b1;
    end
    check("in_valid_seen", {31'b0, found}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, {31'b0, ack}, 32'd0);
    check({tag, "_dat"}, dat_o, 32'd0);
    check({tag, "_opA"}, opa, 32'd0);
    check({tag, "_opB"}, opb, 32'd0);
    check({tag, "_rm"}, {29'b0, rm}, 32'd0);
    check({tag, "_inv"}, {31'b0, inv}, 32'd0);
    check({tag, "_irq"}, {31'b0, irq}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acks;
    #2 rst_l = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;
    wb_read(A_STAT, 32'h0, "status_reset");
    wb_read(A_RES, 32'h0, "result_reset");

    // Basic run with a result after ~60 cycles.
    wb_write(A_OPA, 32'h3F80_0000);
    wb_write(A_OPB, 32'h0000_0000);
    p0 = pulse_cnt;
    wb_write(A_CTRL, 32'h1);
    wait_inval(4);
    check("launch_opA", opa, 32'h3F80_0000);
    check("launch_opB", opb, 32'h0);
    @(negedge clk);
    check("in_valid_one_cycle", {31'b0, inv}, 32'd0);
    repeat (58) @(posedge clk);
    nn_pulse(32'h3F7F_F000);
    check("pulses_run1", pulse_cnt - p0, 32'd1);
    wb_read(A_RES, 32'h3F7F_F000, "result_run1");
    wb_read(A_STAT, 32'h2, "status_done");
    wb_read(A_CTRL, 32'h0, "ctrl_start_reads0");
    wb_write(A_CTRL, 32'h0E);
    wb_read(A_CTRL, 32'h0E, "ctrl_rm7");
    wb_write(A_STAT, 32'h2);
    wb_read(A_STAT, 32'h0, "status_w1c");

    // Timeout: status still busy at the timeout edge, then 0x4.
    wb_write(A_CTRL, 32'h7);
    repeat (127) @(posedge clk);
    wb_read(A_STAT, 32'h1, "status_busy_at_timeout_edge");
    wb_read(A_STAT, 32'h4, "status_timeout");
    wb_read(A_RES, 32'h3F7F_F000, "result_kept_on_timeout");
    nn_pulse(32'hDEAD_BEEF);
    wb_read(A_RES, 32'h3F7F_F000, "valid_ignored_idle");
    wb_read(A_STAT, 32'h4, "status_after_idle_valid");

    // Valid arriving on the timeout edge wins.
    wb_write(A_CTRL, 32'h1);
    repeat (127) @(posedge clk);
    nn_pulse(32'hCAFE_0001);
    wb_read(A_STAT, 32'h2, "valid_beats_timeout");
    wb_read(A_RES, 32'hCAFE_0001, "result_valid_vs_timeout");

    // Writes while busy are ignored; W1C loses to a same-cycle set.
    wb_write(A_OPA, 32'h1111_1111);
    p0 = pulse_cnt;
    wb_write(A_CTRL, 32'h1);
    wb_write(A_OPA, 32'h4000_0000);
    wb_write(A_CTRL, 32'h1);
    wb_write(A_CTRL, 32'h0F);
    check("opA_frozen", opa, 32'h1111_1111);
    check("rm_frozen", {29'b0, rm}, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_STAT; dat = 32'h6;
    nn_val = 1'b1; nn_res = 32'h1234_5678;
    @(posedge clk); #1;
    check("ack_w1c_race", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; nn_val = 1'b0; nn_res = 32'h0;
    check("pulses_busy_start", pulse_cnt - p0, 32'd1);
    wb_read(A_STAT, 32'h2, "set_beats_w1c");
    wb_read(A_RES, 32'h1234_5678, "result_run3");

    // Back-to-back requests ack every other cycle.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_RES;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
    end
    #1 cyc = 1'b0; stb = 1'b0;
    check("back_to_back_acks", acks, 32'd2);

    // Out-of-window accesses.
    wb_read(BASE + 32'h20, 32'h0, "read_0x20");
    wb_read(BASE - 32'h4, 32'h0, "read_below_base");
    wb_write(BASE + 32'h14, 32'hFFFF_FFFF);
    wb_read(A_OPA, 32'h1111_1111, "opa_after_oow_write");
    wb_read(A_CTRL, 32'h0, "ctrl_after_oow_write");
    wb_read(A_RES, 32'h1234_5678, "result_after_oow_write");

    // Configuration-dependent irq behaviour.
    wb_write(A_CTRL, 32'h11);
    wait_inval(4);
    repeat (10) @(posedge clk);
    nn_pulse(32'h0BAD_F00D);
    @(negedge clk);
`ifdef NN_WB_IRQ_EN
    check("irq_on_done", {31'b0, irq}, 32'd1);
    wb_read(A_CTRL, 32'h10, "ctrl_irq_en");
    wb_write(A_STAT, 32'h2);
    @(negedge clk);
    check("irq_cleared", {31'b0, irq}, 32'd0);
`else
    check("irq_tied_low", {31'b0, irq}, 32'd0);
    wb_read(A_CTRL, 32'h0, "ctrl_irq_en_reads0");
`endif

    // Reset in WAIT with a pending request.
    wb_write(A_CTRL, 32'h3);
    repeat (5) @(posedge clk);
    #1 cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_OPA;
    #2 rst_l = 1'b0;
    #1 check_all_zero("midrun_reset");
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_l = 1'b1;
    nn_pulse(32'h0000_0055);
    wb_read(A_STAT, 32'h0, "status_after_reset");
    wb_read(A_RES, 32'h0, "result_after_reset");

    // Reset during LAUNCH suppresses the pulse.
    p0 = pulse_cnt;
    wb_write(A_CTRL, 32'h1);
    #2 rst_l = 1'b0;
    #1 check("launch_reset_inv", {31'b0, inv}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_l = 1'b1;
    check("pulses_after_launch_reset", pulse_cnt - p0, 32'd0);
    wb_read(A_STAT, 32'h0, "status_after_launch_reset");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/nn_wb_ctrl.md
NN_WB_CTRL -- requirements
Module: nn_wb_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, 32'h3000_0000, word-aligned base of the register window.
REQ-002 SHALL have parameter TIMEOUT_CYC, 128, maximum WAIT-state cycles before a timeout is flagged (range 2..65535).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_l  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone cycle, strobe and write-enable.
REQ-006 SHALL have ports wbs_adr_i, wbs_dat_i  input  32 each  Wishbone address and write data.
REQ-007 SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32): acknowledge and read data.
REQ-008 SHALL have ports opA_o, opB_o  output  32 each  operand values driven to the NN core.
REQ-009 SHALL have port round_mode_o  output  3  rounding mode driven to the NN core.
REQ-010 SHALL have port in_valid_o  output  1  one-cycle launch pulse to the NN core.
REQ-011 SHALL have ports nn_result_i (input, 32) and nn_out_valid_i (input, 1): NN core result and its one-cycle valid.
REQ-012 SHALL have port irq_o  output  1  interrupt request.

Function
REQ-013 Register map, as byte offsets from BASE_ADDR:
- 0x00 OPA: RW.
- 0x04 OPB: RW.
- 0x08 CTRL: bit0 START (write-1, reads 0); bits3:1 round_mode; bit4 irq_en.
- 0x0C STATUS: bit0 busy (RO); bit1 done and bit2 timeout (write-1-to-clear).
- 0x10 RESULT: RO.
REQ-014 A request (cyc&stb) SHALL be acked exactly one cycle later with a one-cycle wbs_ack_o pulse.
- No ack is issued in the cycle after an ack, so back-to-back requests each take 2 cycles.
REQ-015 Writes SHALL take effect on the same edge that raises wbs_ack_o.
- Read data SHALL be valid on wbs_dat_o while wbs_ack_o=1; wbs_dat_o SHALL be 0 otherwise.
REQ-016 Accesses outside BASE_ADDR+0x00..0x10 SHALL still be acked: reads return 0 and writes are ignored.
REQ-017 FSM states IDLE, LAUNCH and WAIT SHALL behave as follows:
- IDLE->LAUNCH on a START write while idle.
- LAUNCH->WAIT after exactly 1 cycle, with in_valid_o=1 only during LAUNCH.
- WAIT->IDLE when nn_out_valid_i=1 or on timeout.
REQ-018 busy SHALL equal 1 in LAUNCH and WAIT.
- A START write while busy is ignored; no second pulse and no error.
REQ-019 Writes to OPA, OPB and round_mode SHALL be ignored while busy, so operands stay stable for the whole run.
REQ-020 Leaving IDLE SHALL clear done and timeout.
REQ-021 In WAIT, nn_out_valid_i=1 SHALL load RESULT from nn_result_i, set done and return to IDLE on the next edge.
REQ-022 The WAIT cycle counter SHALL reach TIMEOUT_CYC-1 without a valid, then set timeout, leave RESULT unchanged and return to IDLE.
REQ-023 If nn_out_valid_i and timeout occur in the same cycle, valid SHALL win: done=1, timeout=0.
REQ-024 nn_out_valid_i outside WAIT SHALL be ignored.
REQ-025 A W1C write to STATUS and a hardware set in the same cycle SHALL resolve with the set winning.

Reset
REQ-026 While rst_l=0 the following SHALL be 0 and the FSM in IDLE, independent of clk:
- every register and counter;
- wbs_ack_o, wbs_dat_o, opA_o, opB_o, round_mode_o, in_valid_o, irq_o.
REQ-027 Reset asserted mid-run SHALL abort the run with no in_valid_o pulse and no result capture; a pending ack is dropped.

Configuration
REQ-028 With NN_WB_IRQ_EN defined, irq_o SHALL be registered and equal irq_en & (done | timeout).
REQ-029 Without NN_WB_IRQ_EN, irq_o SHALL be tied 0, and CTRL bit4 SHALL read 0 and ignore writes.

Structure
REQ-030 Package nn_pkg SHALL hold the register offset constants, the STATUS/CTRL bit-position constants and the FSM state enum typedef.
REQ-031 The launch FSM and timeout counter SHALL form one sub-module, nn_launch_fsm.
- The Wishbone decode and register file stay in nn_wb_ctrl.

Verification
REQ-032 Write OPA=0x3F800000, OPB=0x00000000, CTRL=0x1 -> in_valid_o high for exactly 1 cycle with opA_o=0x3F800000 and opB_o=0; model returns 0x3F7FF000 after 60 cycles -> RESULT reads 0x3F7FF000 and STATUS reads 0x2.
REQ-033 START with no nn_out_valid_i and TIMEOUT_CYC=128 -> after 128 WAIT cycles STATUS=0x4 and RESULT holds its previous value.
REQ-034 START, then write OPA=0x40000000 and START again while busy -> one in_valid_o pulse only, opA_o unchanged, both writes acked.
REQ-035 Read at offset 0x20 -> ack after 1 cycle with data 0; write to 0x14 -> ack, no register changes.
REQ-036 rst_l pulled low during WAIT -> all outputs 0 immediately; a later nn_out_valid_i does not set done.
REQ-037 With NN_WB_IRQ_EN, CTRL=0x11 then completion -> irq_o=1; write STATUS=0x2 -> irq_o=0 on the next cycle.
